// File: rtl/lcg_stream_if.sv
// lcg_stream_if: flat stimulus bus carrying one IN_W-bit vector per valid cycle.
// There is no backpressure, so the bus has no ready signal.
interface lcg_stream_if #(parameter int IN_W = 133) ();
    logic            in_valid;
    logic [IN_W-1:0] in_flat;
    modport master (output in_valid, in_flat);
    modport slave  (input in_valid, in_flat);
endinterface

// File: rtl/lcg_stream_checker.sv
// lcg_stream_checker: regenerates the LCG stimulus stream and checks each accepted vector.
// Optional self-consistency relock in SEEK is enabled by defining LCG_CHK_RESYNC_EN.
module lcg_stream_checker #(
    parameter int IN_W     = 133,
    parameter int MAX_MISS = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      seed,
    input  logic             start,
    lcg_stream_if.slave      bus,
    output logic             lock,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      vec_cnt,
    output logic [1:0]       state_o
);
    localparam int UW = IN_W - 128;
    localparam int MW = $clog2(MAX_MISS + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, SEEK = 2'b01, LOCKED = 2'b10} state_t;
    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h3039;
    endfunction
    state_t           state, state_n;
    logic [31:0]      rng, rng_n, vec_n;
    logic [MW-1:0]    miss, miss_n;
    logic [CNT_W-1:0] err_n;
    logic             mismatch_n, hit, resync, rlock;
    logic [31:0]      w0, w1, w2, w3, w4, rs_rng;
    logic [IN_W-1:0]  exp_vec;
    assign w0 = lcg(rng);
    assign w1 = lcg(w0);
    assign w2 = lcg(w1);
    assign w3 = lcg(w2);
    assign w4 = lcg(w3);
    assign exp_vec = {w4[UW-1:0], w3, w2, w1, w0};
    assign hit = bus.in_flat == exp_vec;
`ifdef LCG_CHK_RESYNC_EN
    logic [31:0] c1, c2, c3, c4;
    assign c1 = lcg(bus.in_flat[31:0]);
    assign c2 = lcg(c1);
    assign c3 = lcg(c2);
    assign c4 = lcg(c3);
    assign resync = bus.in_flat[63:32] == c1 && bus.in_flat[95:64] == c2 &&
                    bus.in_flat[127:96] == c3 && bus.in_flat[IN_W-1:128] == c4[UW-1:0];
    assign rs_rng = c4;
`else
    assign resync = 1'b0;
    assign rs_rng = w4;
`endif
    // Seed-derived match wins; self-consistency only matters in SEEK when it fails.
    assign rlock = state == SEEK && !hit && resync;
    always_comb begin
        state_n    = state;
        rng_n      = rng;
        miss_n     = miss;
        mismatch_n = 1'b0;
        err_n      = err_cnt;
        vec_n      = vec_cnt;
        if (start) begin
            state_n = SEEK;
            rng_n   = seed;
            miss_n  = '0;
            err_n   = '0;
            vec_n   = '0;
        end else if (bus.in_valid && state != IDLE) begin
            vec_n = vec_cnt + 32'(vec_cnt != '1);
            rng_n = rlock ? rs_rng : w4;
            if (hit || rlock) begin
                state_n = LOCKED;
                miss_n  = '0;
            end else begin
                mismatch_n = 1'b1;
                err_n      = err_cnt + CNT_W'(err_cnt != '1);
                if (state == LOCKED) begin
                    miss_n  = miss + MW'(1);
                    state_n = miss_n == MW'(MAX_MISS) ? SEEK : LOCKED;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rng      <= '0;
            miss     <= '0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            vec_cnt  <= '0;
            lock     <= 1'b0;
        end else begin
            state    <= state_n;
            rng      <= rng_n;
            miss     <= miss_n;
            mismatch <= mismatch_n;
            err_cnt  <= err_n;
            vec_cnt  <= vec_n;
            lock     <= state_n == LOCKED;
        end
    end
    assign state_o = state;
endmodule
